// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed common-anode seven-segment scanner with
// frame-coherent input snapshot, leading-zero suppression, per-digit
// blank/blink and PWM brightness. All outputs are registered.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int DUTY_W       = 3,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dec_points,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_en,
    input  logic [DUTY_W-1:0]       brightness,
    output logic [7:0]              cathode,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);

    localparam int PRE_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W     = $clog2(NUM_DIGITS);
    localparam int FC_W      = $clog2(BLINK_FRAMES + 1);
    localparam int PHASE_LEN = SCAN_DIV >> DUTY_W;

    // Scan timing state
    logic [PRE_W-1:0]        r_pre;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_frame_done;
    logic [FC_W-1:0]         r_frame_cnt;
    logic                    r_blink_off;

    // Shadow copies of the data inputs, reloaded once per frame
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic [NUM_DIGITS-1:0]   r_blink;
    logic                    r_lz;
    logic [DUTY_W-1:0]       r_bright;

    // Registered pin drivers
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [7:0]              r_cathode;

    logic                    w_tick;
    logic                    w_snap;
    logic [DUTY_W-1:0]       w_phase;
    logic                    w_pwm_on;
    logic [NUM_DIGITS-1:0]   w_sup;
    logic [3:0]              w_nib;
    logic                    w_cur_dp;
    logic                    w_dark;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_anode_nxt;
    logic [7:0]              w_cathode_nxt;

    assign w_tick   = (r_pre == PRE_W'(SCAN_DIV - 1));
    assign w_snap   = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_phase  = DUTY_W'(32'(r_pre) / PHASE_LEN);
    assign w_pwm_on = (w_phase <= r_bright);
    assign w_nib    = r_digits[{r_idx, 2'b00} +: 4];
    assign w_cur_dp = r_dp[r_idx];
    assign w_dark   = w_sup[r_idx] | r_blank[r_idx] | (r_blink[r_idx] & r_blink_off);

    // Prescaler and digit index; index advances on each prescaler wrap
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Snapshot inputs at end of frame, pulse frame_done, run blink counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_digits     <= '0;
            r_dp         <= '0;
            r_blank      <= '0;
            r_blink      <= '0;
            r_lz         <= 1'b0;
            r_bright     <= '0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
            r_blink_off  <= 1'b0;
        end else begin
            r_frame_done <= w_snap;
            if (w_snap) begin
                r_digits <= digits;
                r_dp     <= dec_points;
                r_blank  <= blank_mask;
                r_blink  <= blink_mask;
                r_lz     <= lz_en;
                r_bright <= brightness;
                if (r_frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt <= '0;
                    r_blink_off <= ~r_blink_off;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    // Leading-zero suppression chain, walking down from the top digit
    always_comb begin
        logic v_higher;
        w_sup    = '0;
        v_higher = r_lz;
        for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
            w_sup[NUM_DIGITS-1-k] = v_higher
                                  && (r_digits[4*(NUM_DIGITS-1-k) +: 4] == 4'h0)
                                  && !r_dp[NUM_DIGITS-1-k];
            v_higher = w_sup[NUM_DIGITS-1-k];
        end
    end

    // Hex to active-low segments {g,f,e,d,c,b,a}
    always_comb begin
        w_seg = 7'h7F;
        case (w_nib)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            4'hF: w_seg = 7'h0E;
            default: w_seg = 7'h7F;
        endcase
    end

    // Next pin values: light current digit unless dark or in PWM-off phase
    always_comb begin
        w_anode_nxt   = '1;
        w_cathode_nxt = 8'hFF;
        if (!w_dark && w_pwm_on) begin
            w_anode_nxt   = ~(NUM_DIGITS'(1) << r_idx);
            w_cathode_nxt = {~w_cur_dp, w_seg};
        end
    end

    // Output registers; reset forces the display dark immediately
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_anode   <= '1;
            r_cathode <= 8'hFF;
        end else begin
            r_anode   <= w_anode_nxt;
            r_cathode <= w_cathode_nxt;
        end
    end

    assign anode      = r_anode;
    assign cathode    = r_cathode;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with 4 digits, 8 clocks per slot,
// 4 PWM phases and a 2-frame blink half-period.
module tb_seven_seg_scanner;

    logic        clock;
    logic        reset_n;
    logic [15:0] digits;
    logic [3:0]  dec_points;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic        lz_en;
    logic [1:0]  brightness;
    logic [7:0]  cathode;
    logic [3:0]  anode;
    logic        frame_done;

    int n_assert = 0;
    int n_fail   = 0;

    seven_seg_scanner #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (8),
        .DUTY_W      (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .digits    (digits),
        .dec_points(dec_points),
        .blank_mask(blank_mask),
        .blink_mask(blink_mask),
        .lz_en     (lz_en),
        .brightness(brightness),
        .cathode   (cathode),
        .anode     (anode),
        .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at the negedge right after a snapshot edge and ends at the
    // negedge after the next one. cats = {c3,c2,c1,c0}; lit = digits shown.
    task automatic frame(input string tag, input logic [3:0] lit, input logic [31:0] cats,
                         input int b, input int chg_j, input logic [15:0] chg_val);
        for (int j = 0; j < 32; j++) begin
            int         slot;
            int         ph;
            logic       on;
            logic [3:0] exp_an;
            logic [7:0] exp_cat;
            @(posedge clock);
            @(negedge clock);
            slot    = j / 8;
            ph      = (j % 8) / 2;
            on      = lit[slot] && (ph <= b);
            exp_an  = on ? ~(4'b0001 << slot) : 4'hF;
            exp_cat = on ? cats[slot*8 +: 8] : 8'hFF;
            chk({tag, "_anode"}, 32'(anode), 32'(exp_an));
            chk({tag, "_cathode"}, 32'(cathode), 32'(exp_cat));
            chk({tag, "_frame_done"}, 32'(frame_done), 32'(j == 31));
            if (j == chg_j) digits = chg_val;
        end
    endtask

    // After reset release: check first driven cycle, then count to first snapshot
    task automatic wait_first_snap(input string tag);
        int got;
        got = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k == 1) begin
                chk({tag, "_first_anode"}, 32'(anode), 32'h0000000E);
                chk({tag, "_first_cathode"}, 32'(cathode), 32'h000000C0);
            end
            if (frame_done) begin
                got = k;
                break;
            end
        end
        chk({tag, "_first_snap_clock"}, got, 32);
    endtask

    initial begin
        reset_n    = 1'b0;
        digits     = 16'h0000;
        dec_points = 4'b0000;
        blank_mask = 4'b0000;
        blink_mask = 4'b0000;
        lz_en      = 1'b0;
        brightness = 2'd0;
        repeat (3) @(negedge clock);
        chk("reset_anode", 32'(anode), 32'h0000000F);
        chk("reset_cathode", 32'(cathode), 32'h000000FF);
        chk("reset_frame_done", 32'(frame_done), 32'h0);

        // Basic scan, full brightness
        digits     = 16'h12AF;
        brightness = 2'd3;
        reset_n    = 1'b1;
        wait_first_snap("init");
        frame("scan_a", 4'b1111, 32'hF9A4888E, 3, -1, 16'h0);
        frame("scan_b", 4'b1111, 32'hF9A4888E, 3, -1, 16'h0);

        // Reduced brightness takes effect one frame later
        brightness = 2'd1;
        frame("bright_old", 4'b1111, 32'hF9A4888E, 3, -1, 16'h0);
        frame("bright1", 4'b1111, 32'hF9A4888E, 1, -1, 16'h0);

        // Leading-zero suppression
        brightness = 2'd3;
        lz_en      = 1'b1;
        digits     = 16'h0005;
        frame("lz_prev", 4'b1111, 32'hF9A4888E, 1, -1, 16'h0);
        frame("lz_0005", 4'b0001, 32'hFFFFFF92, 3, -1, 16'h0);
        digits = 16'h0000;
        frame("lz_prev2", 4'b0001, 32'hFFFFFF92, 3, -1, 16'h0);
        frame("lz_0000", 4'b0001, 32'hFFFFFFC0, 3, -1, 16'h0);
        dec_points = 4'b0100;
        frame("lz_prev3", 4'b0001, 32'hFFFFFFC0, 3, -1, 16'h0);
        frame("lz_dp2", 4'b0111, 32'hFF40C0C0, 3, -1, 16'h0);

        // Mid-frame input change must not tear the current frame
        lz_en      = 1'b0;
        dec_points = 4'b0000;
        digits     = 16'h12AF;
        frame("tear_prev", 4'b0111, 32'hFF40C0C0, 3, -1, 16'h0);
        frame("tear_old", 4'b1111, 32'hF9A4888E, 3, 10, 16'h3456);
        frame("tear_new", 4'b1111, 32'hB0999282, 3, -1, 16'h0);

        // Reset during slot 2
        repeat (17) begin
            @(posedge clock);
            @(negedge clock);
        end
        chk("slot2_anode", 32'(anode), 32'h0000000B);
        chk("slot2_cathode", 32'(cathode), 32'h00000099);
        reset_n = 1'b0;
        #1;
        chk("midreset_anode", 32'(anode), 32'h0000000F);
        chk("midreset_cathode", 32'(cathode), 32'h000000FF);
        chk("midreset_frame_done", 32'(frame_done), 32'h0);
        blink_mask = 4'b0001;
        digits     = 16'h12AF;
        repeat (2) @(negedge clock);
        chk("held_reset_anode", 32'(anode), 32'h0000000F);
        reset_n = 1'b1;
        wait_first_snap("rst");

        // Blink: digit 0 lit in frame 1, dark in frames 2-3, lit in 4-5
        frame("blink_f1", 4'b1111, 32'hF9A4888E, 3, -1, 16'h0);
        frame("blink_f2", 4'b1110, 32'hF9A4888E, 3, -1, 16'h0);
        frame("blink_f3", 4'b1110, 32'hF9A4888E, 3, -1, 16'h0);
        frame("blink_f4", 4'b1111, 32'hF9A4888E, 3, -1, 16'h0);
        frame("blink_f5", 4'b1111, 32'hF9A4888E, 3, -1, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised multiplexed seven-segment scanner. It is the next generation of the fixed 8-digit display FSM. It drives NUM_DIGITS common-anode digits from a packed hex word and adds:
- frame-coherent input snapshotting
- leading-zero suppression
- per-digit blanking and blinking
- PWM brightness control

It sits between the timer/formatting logic and the board's anode/cathode pins, and replaces the separate ms clock divider with an internal prescaler.

## Interface
Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..16)
- SCAN_DIV, 100000, clocks per digit slot (1 ms at 100 MHz); must be a multiple of 2^DUTY_W
- DUTY_W, 3, brightness control width; slot split into 2^DUTY_W PWM phases
- BLINK_FRAMES, 125, full frames per blink half-period (≥1)

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- digits  in  4*NUM_DIGITS  hex nibble per digit; nibble i = digit i, digit 0 rightmost
- dec_points  in  NUM_DIGITS  1 = decimal point lit on digit i
- blank_mask  in  NUM_DIGITS  1 = digit i forced dark
- blink_mask  in  NUM_DIGITS  1 = digit i dark during blink-off phase
- lz_en  in  1  1 = leading-zero suppression enabled
- brightness  in  DUTY_W  on-phases per slot = brightness+1
- cathode  out  8  active-low segments; [7]=dp, [6:0]=g,f,e,d,c,b,a
- anode  out  NUM_DIGITS  active-low digit enables; at most one low at any time
- frame_done  out  1  one-clock pulse on each snapshot load

## Operation
- Prescaler `pre` counts 0..SCAN_DIV-1 and wraps. `tick` = (pre == SCAN_DIV-1).
- Digit index `idx` advances on tick and wraps NUM_DIGITS-1 -> 0.
- Snapshot: on tick with idx == NUM_DIGITS-1, all data inputs (digits, dec_points, blank_mask, blink_mask, lz_en, brightness) load into shadow registers and frame_done pulses. The display uses only the shadow values, so changes to the inputs never tear mid-frame.
- Blink: a frame counter counts snapshot events. After BLINK_FRAMES of them, blink_off toggles and the counter clears.
- Leading-zero suppression (lz_en=1): digit i is suppressed if its nibble is 0, every higher digit is suppressed, and its dp is clear. Digit 0 is never suppressed.
- Digit i is dark if any of these holds: suppressed, blank_mask[i], or (blink_mask[i] and blink_off).
- PWM phase = pre / (SCAN_DIV >> DUTY_W). The anode is lit only while phase ≤ brightness.
- Lit digit: anode = ~(1<<idx); cathode = {~dp, hex-decode(nibble)}. The decoder covers full hex 0-F, with lowercase b and d.
- Dark digit or PWM-off: anode all ones, cathode 8'hFF.

## Timing
- Reset (async, immediate):
  - anode all ones, cathode 8'hFF, frame_done 0
  - pre 0, idx 0, blink_off 0, frame counter 0
  - all shadow registers 0
- anode and cathode are registered: they reflect (idx, pre, shadow) with one clock of latency.
- Slot k occupies SCAN_DIV clocks. The anode transition lags the idx change by one clock.
- Input-to-display latency is at most NUM_DIGITS*SCAN_DIV + 2 clocks.
- frame_done is high for exactly the one clock following the snapshot edge.
- Reset asserted mid-frame: outputs go dark immediately. After release, the scan restarts at digit 0, and the first snapshot occurs at clock NUM_DIGITS*SCAN_DIV.
- Simultaneous snapshot and blink toggle: the new blink_off applies from the first slot of the new frame.

## Test plan
1. NUM_DIGITS=4, SCAN_DIV=8, DUTY_W=2, brightness=3, digits=16'h12AF, masks 0, after the first snapshot -> per frame:
   - anode 1110/1101/1011/0111, 8 clocks each
   - cathode 8'h8E/8'h88/8'hA4/8'hF9
   - frame_done every 32 clocks
2. Same setup, brightness=1 -> each anode low 4 of 8 clocks (phases 0,1); cathode 8'hFF for the other 4.
3. lz_en=1:
   - digits=16'h0005 -> digits 3..1 stay dark, digit 0 shows 8'h92
   - digits=16'h0000 -> only digit 0 lit, 8'hC0
   - add dec_points[2]=1 -> digit 2 shows 8'h40 and digit 1 shows 8'hC0
4. BLINK_FRAMES=2, blink_mask=4'b0001 -> digit 0 lit in frames 0-1, dark in frames 2-3, lit again in frames 4-5. Other digits always lit.
5. Change digits mid-frame (during slot 1) -> anode/cathode for the remaining slots unchanged. New value appears in the first slot after the next frame_done.
6. Pull reset_n low during slot 2 -> anode 4'hF and cathode 8'hFF within the same clock. After release, digit 0 is driven (with zero shadow) one clock later, and frame_done first pulses at clock 32.
